fp_add_unpack_align: RTL
========================

Name: fp_add_unpack_align

Overview:
Front-end stage of the floating-point add/subtract pipeline. It accepts two IEEE-754 single-precision operands and an add/sub select, then unpacks and classifies them. It orders them by magnitude and right-shifts the smaller significand to align it with the larger one, tracking guard and sticky bits. Its output feeds the significand add stage, whose result goes to the round/pack stage. It is a 2-stage valid/ready pipeline with backpressure and flush.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width; aligned significand width is MAN_W+3 (hidden, fraction, guard, sticky)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline kill
valid_in  input  1  operands present
ready_in  output  1  stage can accept operands
op_sub  input  1  1 = a - b, 0 = a + b
operand_a  input  32  IEEE-754 single
operand_b  input  32  IEEE-754 single
valid_out  output  1  aligned result present
ready_out  input  1  downstream accepts
sign_large  output  1  sign of larger-magnitude operand (b's sign already inverted when op_sub)
eff_sub  output  1  effective subtraction (sign_large ^ sign_small)
exponent_max  output  8  effective exponent of larger operand
frac_large  output  26  {hidden, fraction, 0, 0}
frac_small  output  26  aligned {hidden, fraction, guard, sticky}
special  output  1  result is fully determined (NaN/Inf/zero case), bypass arithmetic
special_value  output  32  result to use when special=1
inv  output  1  invalid-operation flag

Behaviour:
- Reset (nRST low, async): both stage valids 0, valid_out 0, ready_in 1, all data registers 0.
- Transfers: input accepted when valid_in & ready_in; output consumed when valid_out & ready_out. Latency is exactly 2 cycles with no stall. Throughput is 1 per cycle.
- Stage advance: s2 loads when s2 is empty or ready_out. s1 loads when s1 is empty or s2 loads. ready_in = ~s1_valid | s2_load. This is combinational from ready_out and is the only such path.
- Stalled stages hold all data stable. valid_out never drops without a transfer, except on flush or reset.
- flush: clears s1_valid and s2_valid at the next edge. An input presented in the same cycle is dropped. Flush wins over every simultaneous transfer.
- Stage 1, unpack:
  - hidden = (exp != 0). Effective exponent = 1 when exp == 0 (subnormal), otherwise exp.
  - b sign is xor'd with op_sub.
  - Classify each operand as zero, subnormal, normal, inf, qNaN, or sNaN. NaN means exp all-ones with frac != 0; sNaN additionally has frac[22] = 0.
- Stage 1, order and compare:
  - Compare {exp, frac} unsigned. The larger magnitude becomes "large"; ties keep a as large.
  - exp_diff = eff_exp_large - eff_exp_small, 8-bit, never negative.
  - Register the operands, exp_diff and class bits.
- Stage 2, align:
  - Shift {hidden, frac, 0, 0} of small right by exp_diff.
  - Sticky (bit 0) is the OR of all bits shifted out and the original bit 0.
  - exp_diff >= 26 gives frac_small = {25'b0, (small significand != 0)}.
- Stage 2, special precedence (highest first):
  1. Any NaN input gives special=1 and special_value=32'h7FC00000. inv=1 if either input is an sNaN.
  2. inf + (-inf) under effective subtraction gives 32'h7FC00000 with inv=1.
  3. Any inf gives that infinity, with sign = sign of the inf operand.
  4. Both zero gives a zero with sign = sign_large & sign_small, except under round-to-negative, which stage 3 handles.
  5. Otherwise special=0 and special_value=0.
- Exact zero from cancellation is not detected here; it is resolved downstream.

Decomposition:
- Shared package fpu_pkg:
  - fp_class_t enum (ZERO, SUB, NORM, INF, QNAN, SNAN)
  - fp32_t packed struct {sign, exp[7:0], frac[22:0]}
  - constants CANON_NAN=32'h7FC00000, EXP_ALL_ONES
- One natural sub-module: fp_right_shift_sticky, combinational, parameterised width, inputs value and amount, output aligned value with sticky. It is instantiated in stage 2.

Test Plan:
- 0x3F800000 + 0x3F800000, op_sub=0 -> after 2 cycles: valid_out=1, exponent_max=0x7F, frac_large=frac_small=26'h2000000, eff_sub=0, special=0.
- 0x3F800000 - 0x3F000000 -> exponent_max=0x7F, frac_small=26'h1000000, eff_sub=1, sign_large=0.
- 0x3F800000 + 0x30800000 (exp_diff 30) -> frac_small=26'h0000001 (sticky only).
- 0x7F800000 - 0x7F800000 -> special=1, special_value=0x7FC00000, inv=1.
- Backpressure: stream 4 pairs with ready_out=0 for cycles 2-5 -> ready_in=0 once both stages are full; all 4 results emerge in order and unchanged, with no duplicates.
- Mixed flush and reset: flush asserted with both stages full -> valid_out=0 next cycle, and a subsequent input appears 2 cycles later. nRST pulsed mid-stream -> valid_out=0 immediately (async), ready_in=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared single-precision types, constants and operand helpers
package fpu_pkg;
  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;
  localparam logic [31:0] CANON_NAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  function automatic fp_class_t fp_classify(input fp32_t x);
    if (x.exp == '0) return (x.frac == '0) ? ZERO : SUB;
    if (x.exp == EXP_ALL_ONES) return (x.frac == '0) ? INF : (x.frac[22] ? QNAN : SNAN);
    return NORM;
  endfunction
  // subnormals share the exponent of the smallest normal
  function automatic logic [7:0] fp_eff_exp(input fp32_t x);
    return (x.exp == '0) ? 8'd1 : x.exp;
  endfunction
  function automatic logic fp_is_nan(input fp_class_t c);
    return (c == QNAN) || (c == SNAN);
  endfunction
endpackage

// File: rtl/fp_right_shift_sticky.sv
// fp_right_shift_sticky: right shift that folds every shifted-out bit into bit 0
module fp_right_shift_sticky #(
  parameter int W  = 26,
  parameter int AW = 8
) (
  input  logic [W-1:0]  value,
  input  logic [AW-1:0] amount,
  output logic [W-1:0]  aligned
);
  logic [W-1:0] shifted;
  logic         lost;
  // shift, then OR the discarded low bits into the sticky position
  always_comb begin
    shifted = value >> amount;
    lost = 1'b0;
    for (int i = 0; i < W; i++) lost = lost | (value[i] & (i < int'(amount)));
    aligned = (int'(amount) >= W) ? {{(W-1){1'b0}}, |value} : {shifted[W-1:1], shifted[0] | lost};
  end
endmodule

// File: rtl/fp_add_unpack_align.sv
// fp_add_unpack_align: unpack, order and align two singles ahead of the significand adder
module fp_add_unpack_align #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   operand_a,
  input  logic [EXP_W+MAN_W:0]   operand_b,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic                   sign_large,
  output logic                   eff_sub,
  output logic [EXP_W-1:0]       exponent_max,
  output logic [MAN_W+2:0]       frac_large,
  output logic [MAN_W+2:0]       frac_small,
  output logic                   special,
  output logic [EXP_W+MAN_W:0]   special_value,
  output logic                   inv
);
  import fpu_pkg::*;
  fp32_t            a, b, big, sml, s1_big, s1_sml;
  fp_class_t        s1_bcls, s1_scls;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_valid, s2_valid, s1_load, s2_load, a_large;
  logic [MAN_W+2:0] sig_l, sig_s, aligned;
  logic             any_nan, any_snan, inf_inf, any_inf, both_zero, sp_n, inv_n;
  logic [31:0]      sv_n;
  assign a         = operand_a;
  assign b         = {operand_b[31] ^ op_sub, operand_b[30:0]};
  assign a_large   = a[30:0] >= b[30:0];
  assign big       = a_large ? a : b;
  assign sml       = a_large ? b : a;
  assign s2_load   = ~s2_valid | ready_out;
  assign s1_load   = ~s1_valid | s2_load;
  assign ready_in  = s1_load;
  assign valid_out = s2_valid;
  // stage 1: capture ordered operands, exponent gap and classes on acceptance
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_big   <= '0;
      s1_sml   <= '0;
      s1_diff  <= '0;
      s1_bcls  <= ZERO;
      s1_scls  <= ZERO;
    end else begin
      s1_valid <= ~flush & (s1_load ? valid_in : s1_valid);
      if (valid_in & ready_in) begin
        s1_big  <= big;
        s1_sml  <= sml;
        s1_diff <= fp_eff_exp(big) - fp_eff_exp(sml);
        s1_bcls <= fp_classify(big);
        s1_scls <= fp_classify(sml);
      end
    end
  assign sig_l = {s1_big.exp != '0, s1_big.frac, 2'b00};
  assign sig_s = {s1_sml.exp != '0, s1_sml.frac, 2'b00};
  fp_right_shift_sticky #(.W(MAN_W+3), .AW(EXP_W)) u_align (
    .value  (sig_s),
    .amount (s1_diff),
    .aligned(aligned)
  );
  // special-case resolution; an infinity without NaNs is always the large operand
  always_comb begin
    any_nan   = fp_is_nan(s1_bcls) | fp_is_nan(s1_scls);
    any_snan  = (s1_bcls == SNAN) | (s1_scls == SNAN);
    inf_inf   = (s1_bcls == INF) & (s1_scls == INF) & (s1_big.sign ^ s1_sml.sign);
    any_inf   = (s1_bcls == INF) | (s1_scls == INF);
    both_zero = (s1_bcls == ZERO) & (s1_scls == ZERO);
    sp_n      = any_nan | any_inf | both_zero;
    inv_n     = any_snan | (~any_nan & inf_inf);
    sv_n      = (any_nan | inf_inf) ? CANON_NAN :
                any_inf ? {s1_big.sign, EXP_ALL_ONES, 23'b0} :
                both_zero ? {s1_big.sign & s1_sml.sign, 31'b0} : 32'b0;
  end
  // stage 2: register the aligned result while downstream has room
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      s2_valid      <= 1'b0;
      sign_large    <= 1'b0;
      eff_sub       <= 1'b0;
      exponent_max  <= '0;
      frac_large    <= '0;
      frac_small    <= '0;
      special       <= 1'b0;
      special_value <= '0;
      inv           <= 1'b0;
    end else begin
      s2_valid <= ~flush & (s2_load ? s1_valid : s2_valid);
      if (s2_load & s1_valid) begin
        sign_large    <= s1_big.sign;
        eff_sub       <= s1_big.sign ^ s1_sml.sign;
        exponent_max  <= fp_eff_exp(s1_big);
        frac_large    <= sig_l;
        frac_small    <= aligned;
        special       <= sp_n;
        special_value <= sv_n;
        inv           <= inv_n;
      end
    end
endmodule
